frog_key_decoder: RTL and testbench

//  Producer side of the frog movement interface: turns a PS/2 scan-code byte stream into the
//  up/down/left/right held levels consumed by frog_move, plus a one-cycle start pulse.

---
 rtl/frog_key_if.sv | 22 ++
 rtl/frog_key_decoder.sv | 143 ++++++++++++++
 tb/tb_frog_key_decoder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/frog_key_if.sv
// Byte-stream / key-level bundle between the PS/2 byte receiver, frog_key_decoder and frog_move.
// The master drives scan-code bytes and clear_keys; the slave (the decoder) drives the key levels.
interface frog_key_if;
    logic [7:0] din;
    logic       din_valid;
    logic       clear_keys;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       start_pulse;

    modport master (
        output din, din_valid, clear_keys,
        input  up, down, left, right, start_pulse
    );

    modport slave (
        input  din, din_valid, clear_keys,
        output up, down, left, right, start_pulse
    );
endinterface

// File: rtl/frog_key_decoder.sv
// Turns a PS/2 scan-code byte stream into held arrow levels and an Enter start pulse.
// Opposite-direction conflicts are resolved so that the newest press wins.
module frog_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TO_W           = 21
) (
    input  logic       CLK,
    input  logic       RESETn,
    frog_key_if.slave  key_if
);

    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeBrk   = 8'hF0;
    localparam logic [7:0] CodeEnter = 8'h5A;
    localparam logic [7:0] CodeUp    = 8'h75;
    localparam logic [7:0] CodeDown  = 8'h72;
    localparam logic [7:0] CodeLeft  = 8'h6B;
    localparam logic [7:0] CodeRight = 8'h74;
    localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, EXT_BRK, BRK} state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            heldUp_q, heldUp_d, heldDown_q, heldDown_d;
    logic            heldLeft_q, heldLeft_d, heldRight_q, heldRight_d;
    logic            priV_q, priV_d, priH_q, priH_d;
    logic            up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
    logic            start_q, start_d;

    // Priority bits only move on a fresh press, so typematic repeats leave them alone.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        heldUp_d    = heldUp_q;
        heldDown_d  = heldDown_q;
        heldLeft_d  = heldLeft_q;
        heldRight_d = heldRight_q;
        priV_d      = priV_q;
        priH_d      = priH_q;
        start_d     = 1'b0;

        if (key_if.clear_keys) begin
            state_d     = IDLE;
            cnt_d       = '0;
            heldUp_d    = 1'b0;
            heldDown_d  = 1'b0;
            heldLeft_d  = 1'b0;
            heldRight_d = 1'b0;
            priV_d      = 1'b0;
            priH_d      = 1'b0;
        end else if (key_if.din_valid) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (key_if.din == CodeExt)        state_d = EXT;
                    else if (key_if.din == CodeBrk)   state_d = BRK;
                    else if (key_if.din == CodeEnter) start_d = 1'b1;
                end
                EXT: begin
                    state_d = (key_if.din == CodeBrk) ? EXT_BRK : IDLE;
                    if (key_if.din == CodeUp && !heldUp_q) begin
                        heldUp_d = 1'b1;
                        priV_d   = 1'b1;
                    end
                    if (key_if.din == CodeDown && !heldDown_q) begin
                        heldDown_d = 1'b1;
                        priV_d     = 1'b0;
                    end
                    if (key_if.din == CodeLeft && !heldLeft_q) begin
                        heldLeft_d = 1'b1;
                        priH_d     = 1'b1;
                    end
                    if (key_if.din == CodeRight && !heldRight_q) begin
                        heldRight_d = 1'b1;
                        priH_d      = 1'b0;
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (key_if.din == CodeUp)    heldUp_d    = 1'b0;
                    if (key_if.din == CodeDown)  heldDown_d  = 1'b0;
                    if (key_if.din == CodeLeft)  heldLeft_d  = 1'b0;
                    if (key_if.din == CodeRight) heldRight_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CntLast) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        up_d    = heldUp_d    & (~heldDown_d  | priV_d);
        down_d  = heldDown_d  & (~heldUp_d    | ~priV_d);
        left_d  = heldLeft_d  & (~heldRight_d | priH_d);
        right_d = heldRight_d & (~heldLeft_d  | ~priH_d);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            heldUp_q    <= 1'b0;
            heldDown_q  <= 1'b0;
            heldLeft_q  <= 1'b0;
            heldRight_q <= 1'b0;
            priV_q      <= 1'b0;
            priH_q      <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            heldUp_q    <= heldUp_d;
            heldDown_q  <= heldDown_d;
            heldLeft_q  <= heldLeft_d;
            heldRight_q <= heldRight_d;
            priV_q      <= priV_d;
            priH_q      <= priH_d;
            up_q        <= up_d;
            down_q      <= down_d;
            left_q      <= left_d;
            right_q     <= right_d;
            start_q     <= start_d;
        end
    end

    assign key_if.up          = up_q;
    assign key_if.down        = down_q;
    assign key_if.left        = left_q;
    assign key_if.right       = right_q;
    assign key_if.start_pulse = start_q;

endmodule

// File: tb/tb_frog_key_decoder.sv
// Directed self-checking bench for frog_key_decoder, using a short timeout so the
// timeout behaviour can be exercised within a small number of cycles.
module tb_frog_key_decoder;

    localparam int TIMEOUT_CYCLES = 16;
    localparam int TO_W           = 5;

    logic CLK;
    logic RESETn;
    int   total;
    int   bad;

    frog_key_if keyIf ();

    frog_key_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) dut (
        .CLK   (CLK),
        .RESETn(RESETn),
        .key_if(keyIf.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Presents one byte for exactly one rising edge; called at posedge+1, returns at posedge+1.
    task automatic applyStimulus(input logic [7:0] b);
        keyIf.din       = b;
        keyIf.din_valid = 1'b1;
        @(posedge CLK);
        #1;
        keyIf.din_valid = 1'b0;
    endtask

    // Expected bits ordered {up, down, left, right, start_pulse}.
    task automatic checkOutput(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        observed = {keyIf.up, keyIf.down, keyIf.left, keyIf.right, keyIf.start_pulse};
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        RESETn           = 1'b0;
        keyIf.din        = 8'h00;
        keyIf.din_valid  = 1'b0;
        keyIf.clear_keys = 1'b0;
        #12;
        checkOutput("reset", 5'b00000);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("after_reset", 5'b00000);

        // 1: press and release up
        applyStimulus(8'hE0);
        checkOutput("t1_prefix", 5'b00000);
        applyStimulus(8'h75);
        checkOutput("t1_up_make", 5'b10000);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        checkOutput("t1_up_brk_partial", 5'b10000);
        applyStimulus(8'h75);
        checkOutput("t1_up_break", 5'b00000);

        // 2: vertical conflict, newest wins, release reveals the older key
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        applyStimulus(8'hE0);
        applyStimulus(8'h72);
        checkOutput("t2_down_wins", 5'b01000);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h72);
        checkOutput("t2_up_revealed", 5'b10000);
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        checkOutput("t2_typematic", 5'b10000);
        applyStimulus(8'hE0);
        applyStimulus(8'h72);
        checkOutput("t2_down_again", 5'b01000);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h72);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        checkOutput("t2_all_released", 5'b00000);

        // 3: diagonal, horizontal conflict, clear_keys with coincident byte
        applyStimulus(8'hE0);
        applyStimulus(8'h6B);
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        checkOutput("t3_diagonal", 5'b10100);
        applyStimulus(8'hE0);
        applyStimulus(8'h74);
        checkOutput("t3_right_wins", 5'b10010);
        keyIf.clear_keys = 1'b1;
        applyStimulus(8'hE0);
        keyIf.clear_keys = 1'b0;
        checkOutput("t3_clear", 5'b00000);
        applyStimulus(8'h75);
        checkOutput("t3_clear_dropped_byte", 5'b00000);

        // 4: Enter make pulse, Enter release and keypad Enter
        applyStimulus(8'h5A);
        checkOutput("t4_start_pulse", 5'b00001);
        @(posedge CLK);
        #1;
        checkOutput("t4_pulse_one_cycle", 5'b00000);
        applyStimulus(8'hF0);
        applyStimulus(8'h5A);
        checkOutput("t4_enter_release", 5'b00000);
        applyStimulus(8'hE0);
        applyStimulus(8'h5A);
        checkOutput("t4_keypad_enter", 5'b00000);
        applyStimulus(8'h5A);
        checkOutput("t4_idle_after_keypad", 5'b00001);

        // 5: timeout discards a partial code; a shorter gap does not
        applyStimulus(8'hE0);
        repeat (TIMEOUT_CYCLES) @(posedge CLK);
        #1;
        applyStimulus(8'h75);
        checkOutput("t5_timeout_discard", 5'b00000);
        applyStimulus(8'h5A);
        checkOutput("t5_idle_after_timeout", 5'b00001);
        applyStimulus(8'hE0);
        repeat (TIMEOUT_CYCLES - 2) @(posedge CLK);
        #1;
        applyStimulus(8'h75);
        checkOutput("t5_gap_ok", 5'b10000);
        keyIf.clear_keys = 1'b1;
        @(posedge CLK);
        #1;
        keyIf.clear_keys = 1'b0;
        checkOutput("t5_cleanup", 5'b00000);

        // 6: fake-shift prefix, then async reset in the middle of a break
        applyStimulus(8'hE0);
        applyStimulus(8'h12);
        applyStimulus(8'hE0);
        applyStimulus(8'h74);
        checkOutput("t6_fake_shift", 5'b00010);
        applyStimulus(8'hE0);
        #2;
        RESETn = 1'b0;
        #1;
        checkOutput("t6_async_reset", 5'b00000);
        #1;
        RESETn = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(8'hF0);
        applyStimulus(8'h74);
        checkOutput("t6_trailing_bytes", 5'b00000);
        applyStimulus(8'hE0);
        applyStimulus(8'h74);
        checkOutput("t6_right_after_reset", 5'b00010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
